// File: rtl/riscv_pkg.sv
// Shared fetch-side types: the canonical NOP and the fetch buffer slot layout.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// In-order fetch buffer: a slot is allocated at grant (pc), filled at response (instr), freed at pop.
// The head view forwards a same-cycle fill so a response is visible in the cycle it arrives.
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            alloc_i,
    input  logic [XLEN-1:0] alloc_pc_i,
    input  logic            fill_i,
    input  logic [XLEN-1:0] fill_instr_i,
    input  logic            pop_i,
    output fetch_entry_t    head_o,
    output logic [CW-1:0]   count_o,
    output logic [CW-1:0]   pend_o,
    output logic            full_o,
    output logic            empty_o
);

    fetch_entry_t  slots_q [DEPTH];
    fetch_entry_t  slots_d [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d, fill_q, fill_d;
    logic [CW-1:0] count_q, count_d, pend_q, pend_d;

    always_comb begin
        slots_d = slots_q;
        if (alloc_i) begin
            slots_d[tail_q].pc     = alloc_pc_i;
            slots_d[tail_q].filled = 1'b0;
        end
        if (fill_i) begin
            slots_d[fill_q].instr  = fill_instr_i;
            slots_d[fill_q].filled = 1'b1;
        end
    end

    always_comb begin
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            fill_d  = '0;
            count_d = '0;
            pend_d  = '0;
        end else begin
            head_d  = head_q + PW'(pop_i);
            tail_d  = tail_q + PW'(alloc_i);
            fill_d  = fill_q + PW'(fill_i);
            count_d = count_q + CW'(alloc_i) - CW'(pop_i);
            pend_d  = pend_q + CW'(alloc_i) - CW'(fill_i);
        end
    end

    // Responses return in order, so an unfilled head is always the fill target.
    always_comb begin
        head_o = slots_q[head_q];
        if (fill_i && (fill_q == head_q)) begin
            head_o.instr  = fill_instr_i;
            head_o.filled = 1'b1;
        end
        count_o = count_q;
        pend_o  = pend_q;
        full_o  = (count_q == CW'(DEPTH));
        empty_o = (count_q == '0);
    end

    always_ff @(posedge clk_i) begin
        slots_q <= slots_d;
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
            pend_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            fill_q  <= fill_d;
            count_q <= count_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: owns the PC, issues imem requests, drops wrong-path responses after a redirect.
// Optional FETCH_PERF_CNT_EN adds bubble/redirect performance counters.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int          DW        = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic          imem_req_o,
    output logic [DW-1:0] imem_addr_o,
    input  logic          imem_gnt_i,
    input  logic          imem_rvalid_i,
    input  logic [DW-1:0] imem_rdata_i,
    input  logic          stall_i,
    input  logic          redirect_i,
    input  logic [DW-1:0] redirect_pc_i,
    output logic [DW-1:0] instr_f,
    output logic [DW-1:0] pc_f,
    output logic [DW-1:0] pc_plus_4_f,
    output logic          fetch_valid_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   perf_bubble_o,
    output logic [31:0]   perf_redirect_o
`endif
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_entry_t  head;
    logic [CW-1:0] buf_count, buf_pend;
    logic          buf_full, buf_empty;
    logic          grant, fill, pop;
    logic [DW-1:0] req_pc_q, req_pc_d;
    logic [CW-1:0] drop_q, drop_d;

    fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (redirect_i),
        .alloc_i      (grant),
        .alloc_pc_i   (XLEN'(req_pc_q)),
        .fill_i       (fill),
        .fill_instr_i (XLEN'(imem_rdata_i)),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (buf_count),
        .pend_o       (buf_pend),
        .full_o       (buf_full),
        .empty_o      (buf_empty)
    );

    // Outstanding wrong-path responses still occupy imem slots, so they count against the depth.
    always_comb begin
        imem_req_o    = !rst_i && !redirect_i && !buf_full
                        && ((int'(buf_count) + int'(drop_q)) < BUF_DEPTH);
        imem_addr_o   = req_pc_q;
        grant         = imem_req_o && imem_gnt_i;
        fill          = imem_rvalid_i && (drop_q == '0) && !redirect_i;
        fetch_valid_o = !buf_empty && head.filled;
        instr_f       = fetch_valid_o ? DW'(head.instr) : DW'(NOP_INSTR);
        pc_f          = fetch_valid_o ? DW'(head.pc) : '0;
        pc_plus_4_f   = pc_f + DW'(4);
        pop           = fetch_valid_o && !stall_i && !redirect_i;
    end

    always_comb begin
        req_pc_d = req_pc_q;
        drop_d   = drop_q;
        if (redirect_i) begin
            req_pc_d = redirect_pc_i & ~DW'(3);
            drop_d   = drop_q + buf_pend - CW'(imem_rvalid_i);
        end else begin
            if (grant) req_pc_d = req_pc_q + DW'(4);
            if (imem_rvalid_i && (drop_q != '0)) drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_pc_q <= DW'(RESET_PC);
            drop_q   <= '0;
        end else begin
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bubble_q, bubble_d, redir_q, redir_d;

    always_comb begin
        bubble_d = bubble_q;
        redir_d  = redir_q;
        if (!fetch_valid_o && !stall_i && (bubble_q != '1)) bubble_d = bubble_q + 32'd1;
        if (redirect_i && (redir_q != '1)) redir_d = redir_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bubble_q <= '0;
            redir_q  <= '0;
        end else begin
            bubble_q <= bubble_d;
            redir_q  <= redir_d;
        end
    end

    assign perf_bubble_o   = bubble_q;
    assign perf_redirect_o = redir_q;
`else
    // Counters are not built; fetch behaviour is unchanged.
`endif

endmodule
